// File: rtl/red_seq_unit_pkg.sv
// Shared types and constants for the sequential nibble-reduction responder.
package red_seq_unit_pkg;

    localparam int unsigned NIB_W       = 4;
    localparam int unsigned RED_NIBBLES = 4;
    localparam int unsigned OP_W        = NIB_W * RED_NIBBLES;
    localparam int unsigned RW          = 16;
    localparam int unsigned PAIR_W      = NIB_W + 1;
    localparam int unsigned IDX_W       = $clog2(RED_NIBBLES);
    localparam int unsigned SEL_W       = $clog2(OP_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } red_state_t;

    // Operand pair captured on request accept
    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } red_ops_t;

    function automatic logic [PAIR_W-1:0] sext_nib(input logic [NIB_W-1:0] nib);
        return {nib[NIB_W-1], nib};
    endfunction

endpackage

// File: rtl/red_seq_unit_if.sv
// Request/response channel between the ALU (master) and the RED responder (slave).
interface red_seq_unit_if;
    import red_seq_unit_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [OP_W-1:0] A;
    logic [OP_W-1:0] B;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [RW-1:0]   R;
    logic            busy;

    modport master (
        output req_valid, A, B, rsp_ready,
        input  req_ready, rsp_valid, R, busy
    );

    modport slave (
        input  req_valid, A, B, rsp_ready,
        output req_ready, rsp_valid, R, busy
    );

endinterface

// File: rtl/red_seq_unit_nibble_sadd.sv
// Signed add of one 4-bit nibble pair into a 5-bit result (range -16..+14).
module red_seq_unit_nibble_sadd
    import red_seq_unit_pkg::*;
(
    input  logic [NIB_W-1:0]         a_nib,
    input  logic [NIB_W-1:0]         b_nib,
    output logic signed [PAIR_W-1:0] sum_c
);

    always_comb begin
        sum_c = $signed(sext_nib(a_nib)) + $signed(sext_nib(b_nib));
    end

endmodule

// File: rtl/red_seq_unit.sv
// Multi-cycle RED responder: accumulates one signed nibble pair per cycle, then
// holds the result on a valid/ready response channel until it is taken.
module red_seq_unit
    import red_seq_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    red_seq_unit_if.slave  bus
);

    red_state_t              state_q, state_d;
    red_ops_t                ops_q, ops_d;
    logic [RW-1:0]           acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [RW-1:0]           r_q, r_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;

    logic [SEL_W-1:0]        sel_c;
    logic [NIB_W-1:0]        a_nib_c;
    logic [NIB_W-1:0]        b_nib_c;
    logic signed [PAIR_W-1:0] pair_sum_c;
    logic [RW-1:0]           term_c;

    // Select the current nibble pair from the latched operands
    always_comb begin
        sel_c   = SEL_W'(32'(idx_q) * NIB_W);
        a_nib_c = ops_q.a[sel_c +: NIB_W];
        b_nib_c = ops_q.b[sel_c +: NIB_W];
        term_c  = {{(RW-PAIR_W){pair_sum_c[PAIR_W-1]}}, pair_sum_c};
    end

    red_seq_unit_nibble_sadd u_sadd (
        .a_nib (a_nib_c),
        .b_nib (b_nib_c),
        .sum_c (pair_sum_c)
    );

    always_comb begin
        state_d     = state_q;
        ops_d       = ops_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        r_d         = r_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    ops_d.a     = bus.A;
                    ops_d.b     = bus.B;
                    acc_d       = '0;
                    idx_d       = '0;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + term_c;
                idx_d = idx_q + IDX_W'(1);
                // Last pair goes straight into R so the response is ready on entering DONE
                if (idx_q == IDX_W'(RED_NIBBLES - 1)) begin
                    r_d         = acc_q + term_c;
                    rsp_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ops_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            r_q         <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ops_q       <= ops_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            r_q         <= r_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.R         = r_q;
    assign bus.busy      = busy_q;

endmodule
